// File: rtl/bus_rr_arbiter.sv
// Shared-bus arbiter for NREQ masters: round-robin or fixed-priority selection,
// registered one-hot grant, one idle turnaround cycle, bounded hold under contention.
module bus_rr_arbiter #(
  parameter  int NREQ       = 8,
  parameter  int MAXHOLD    = 16,
  parameter  int FIXED_PRIO = 0,
  localparam int OW         = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] bus_req,
  output logic [NREQ-1:0] bus_ack,
  input  logic            bus_rd,
  input  logic            bus_wr,
  input  logic            bus_ready,
  output logic            bus_busy,
  output logic [OW-1:0]   bus_owner
);

  typedef enum logic [1:0] {IDLE, OWNED, TURN} state_t;

  localparam int            CW       = $clog2(MAXHOLD + 1);
  localparam logic [CW-1:0] HOLD_MAX = CW'(MAXHOLD);

  state_t          state_q, state_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic [OW-1:0]   owner_q, owner_d;
  logic [OW-1:0]   ptr_q, ptr_d;
  logic [CW-1:0]   hold_q, hold_d;
  logic            busy_q, busy_d;

  logic [NREQ-1:0] above_ptr, below_owner, req_above, others;
  logic [OW-1:0]   win_idx;
  logic            owner_req, quiescent, preempt_comp;

  function automatic logic [OW-1:0] lowest_set(input logic [NREQ-1:0] v);
    lowest_set = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (v[i]) lowest_set = OW'(i);
    end
  endfunction

  // Winner search: round-robin prefers indices above the pointer, then wraps.
  always_comb begin
    above_ptr   = '0;
    below_owner = '0;
    for (int i = 0; i < NREQ; i++) begin
      above_ptr[i]   = OW'(i) > ptr_q;
      below_owner[i] = OW'(i) < owner_q;
    end
    req_above = bus_req & above_ptr;
    if (FIXED_PRIO != 0)  win_idx = lowest_set(bus_req);
    else if (|req_above)  win_idx = lowest_set(req_above);
    else                  win_idx = lowest_set(bus_req);

    others       = bus_req & ~ack_q;
    owner_req    = |(bus_req & ack_q);
    quiescent    = (!bus_rd && !bus_wr) || bus_ready;
    preempt_comp = (FIXED_PRIO != 0) ? |(others & below_owner) : |others;
  end

  always_comb begin
    // NOTE: every _d gets a default first so no path through the case can infer a latch.
    state_d = state_q;
    ack_d   = ack_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    unique case (state_q)
      IDLE, TURN: begin
        if (|bus_req) begin
          state_d          = OWNED;
          ack_d            = '0;
          ack_d[win_idx]   = 1'b1;
          owner_d          = win_idx;
          ptr_d            = win_idx;
          hold_d           = '0;
        end else begin
          state_d = IDLE;
          ack_d   = '0;
          owner_d = '0;
        end
      end
      OWNED: begin
        // Release on request drop (even mid-transfer) or on a safe preempt.
        if (!owner_req || (hold_q == HOLD_MAX && preempt_comp && quiescent)) begin
          state_d = TURN;
          ack_d   = '0;
          owner_d = '0;
          hold_d  = '0;
        end else if (|others && hold_q != HOLD_MAX) begin
          hold_d = hold_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        ack_d   = '0;
        owner_d = '0;
      end
    endcase
    busy_d = |ack_d;
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ack_q   <= '0;
      owner_q <= '0;
      ptr_q   <= OW'(NREQ - 1);
      hold_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      busy_q  <= busy_d;
    end
  end

  assign bus_ack   = ack_q;
  assign bus_busy  = busy_q;
  assign bus_owner = owner_q;

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Directed bench for bus_rr_arbiter: a round-robin instance and a fixed-priority
// instance (both NREQ=4) driven from a vector table plus multi-cycle sequences.
module tb_bus_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       bus_rd, bus_wr, bus_ready;
  logic [3:0] req_rr, ack_rr, req_fp, ack_fp;
  logic [1:0] owner_rr, owner_fp;
  logic       busy_rr, busy_fp;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [3:0] req;
    logic [3:0] ack;
    logic [1:0] owner;
  } vec_t;

  vec_t tbl[$];

  bus_rr_arbiter #(.NREQ(4), .MAXHOLD(4), .FIXED_PRIO(0)) u_rr (
    .clk(clk), .rst(rst), .bus_req(req_rr), .bus_ack(ack_rr),
    .bus_rd(bus_rd), .bus_wr(bus_wr), .bus_ready(bus_ready),
    .bus_busy(busy_rr), .bus_owner(owner_rr)
  );

  bus_rr_arbiter #(.NREQ(4), .MAXHOLD(2), .FIXED_PRIO(1)) u_fp (
    .clk(clk), .rst(rst), .bus_req(req_fp), .bus_ack(ack_fp),
    .bus_rd(bus_rd), .bus_wr(bus_wr), .bus_ready(bus_ready),
    .bus_busy(busy_fp), .bus_owner(owner_fp)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_rr(input string tag, input logic [3:0] ack, input logic [1:0] own);
    check({tag, "_ack"},   32'(ack_rr),   32'(ack));
    check({tag, "_owner"}, 32'(owner_rr), 32'(own));
    check({tag, "_busy"},  32'(busy_rr),  32'(ack != 4'h0));
  endtask

  task automatic expect_fp(input string tag, input logic [3:0] ack, input logic [1:0] own);
    check({tag, "_ack"},   32'(ack_fp),   32'(ack));
    check({tag, "_owner"}, 32'(owner_fp), 32'(own));
    check({tag, "_busy"},  32'(busy_fp),  32'(ack != 4'h0));
  endtask

  // Drive one cycle of inputs at a falling edge; outputs are sampled at the next one.
  task automatic step_rr(input logic [3:0] rq, input logic rd, input logic rdy);
    req_rr    = rq;
    bus_rd    = rd;
    bus_ready = rdy;
    @(negedge clk);
  endtask

  task automatic step_fp(input logic [3:0] rq);
    req_fp = rq;
    @(negedge clk);
  endtask

  task automatic add(input logic [3:0] rq, input logic [3:0] ack, input logic [1:0] own);
    vec_t v;
    v.req   = rq;
    v.ack   = ack;
    v.owner = own;
    tbl.push_back(v);
  endtask

  initial begin
    rst = 1'b1; req_rr = '0; req_fp = '0;
    bus_rd = 1'b0; bus_wr = 1'b0; bus_ready = 1'b0;

    // Round-robin fairness from reset (pointer starts at 3), then a lone request.
    add(4'hF, 4'h1, 2'd0); add(4'hF, 4'h1, 2'd0); add(4'hF, 4'h1, 2'd0); add(4'hE, 4'h0, 2'd0);
    add(4'hF, 4'h2, 2'd1); add(4'hF, 4'h2, 2'd1); add(4'hF, 4'h2, 2'd1); add(4'hD, 4'h0, 2'd0);
    add(4'hF, 4'h4, 2'd2); add(4'hF, 4'h4, 2'd2); add(4'hF, 4'h4, 2'd2); add(4'hB, 4'h0, 2'd0);
    add(4'hF, 4'h8, 2'd3); add(4'hF, 4'h8, 2'd3); add(4'hF, 4'h8, 2'd3); add(4'h7, 4'h0, 2'd0);
    add(4'hF, 4'h1, 2'd0); add(4'h0, 4'h0, 2'd0); add(4'h0, 4'h0, 2'd0);
    add(4'h4, 4'h4, 2'd2); add(4'h4, 4'h4, 2'd2); add(4'h0, 4'h0, 2'd0); add(4'h0, 4'h0, 2'd0);

    #2;
    expect_rr("reset_rr", 4'h0, 2'd0);
    expect_fp("reset_fp", 4'h0, 2'd0);
    @(negedge clk);
    rst = 1'b0;

    foreach (tbl[i]) begin
      step_rr(tbl[i].req, 1'b0, 1'b0);
      expect_rr($sformatf("vec%0d", i), tbl[i].ack, tbl[i].owner);
    end

    // Preemption blocked by an unfinished read; pointer is 2, so master 0 wins.
    step_rr(4'h3, 1'b0, 1'b0);
    expect_rr("blk_grant", 4'h1, 2'd0);
    for (int i = 0; i < 10; i++) begin
      step_rr(4'h3, 1'b1, 1'b0);
      expect_rr($sformatf("blk_hold%0d", i), 4'h1, 2'd0);
    end
    step_rr(4'h3, 1'b1, 1'b1);
    expect_rr("blk_revoke", 4'h0, 2'd0);
    step_rr(4'h3, 1'b0, 1'b0);
    expect_rr("blk_next", 4'h2, 2'd1);
    step_rr(4'h0, 1'b0, 1'b0);
    step_rr(4'h0, 1'b0, 1'b0);
    expect_rr("blk_idle", 4'h0, 2'd0);

    // Preemption on a quiescent bus after MAXHOLD contended cycles.
    step_rr(4'h1, 1'b0, 1'b0);
    expect_rr("qp_grant", 4'h1, 2'd0);
    for (int i = 0; i < 4; i++) begin
      step_rr(4'h9, 1'b0, 1'b0);
      expect_rr($sformatf("qp_hold%0d", i), 4'h1, 2'd0);
    end
    step_rr(4'h9, 1'b0, 1'b0);
    expect_rr("qp_revoke", 4'h0, 2'd0);
    step_rr(4'h9, 1'b0, 1'b0);
    expect_rr("qp_next", 4'h8, 2'd3);
    step_rr(4'h0, 1'b0, 1'b0);
    step_rr(4'h0, 1'b0, 1'b0);

    // Owner dropping request mid-transfer still releases the bus.
    step_rr(4'h4, 1'b0, 1'b0);
    expect_rr("perr_grant", 4'h4, 2'd2);
    step_rr(4'h0, 1'b1, 1'b0);
    expect_rr("perr_release", 4'h0, 2'd0);
    step_rr(4'h0, 1'b0, 1'b0);

    // Asynchronous reset while master 2 owns the bus.
    step_rr(4'h4, 1'b0, 1'b0);
    expect_rr("arst_grant", 4'h4, 2'd2);
    req_rr = 4'h1;
    #2 rst = 1'b1;
    #1 expect_rr("arst_async", 4'h0, 2'd0);
    #1 rst = 1'b0;
    @(negedge clk);
    expect_rr("arst_after", 4'h1, 2'd0);
    step_rr(4'h0, 1'b0, 1'b0);
    step_rr(4'h0, 1'b0, 1'b0);

    // Fixed priority: a higher index never preempts, a lower index does.
    step_fp(4'hC);
    expect_fp("fp_grant", 4'h4, 2'd2);
    for (int i = 0; i < 3; i++) begin
      step_fp(4'hC);
      expect_fp($sformatf("fp_hi%0d", i), 4'h4, 2'd2);
    end
    step_fp(4'hD);
    expect_fp("fp_revoke", 4'h0, 2'd0);
    step_fp(4'hD);
    expect_fp("fp_low", 4'h1, 2'd0);
    for (int i = 0; i < 6; i++) begin
      step_fp(4'h9);
      expect_fp($sformatf("fp_keep%0d", i), 4'h1, 2'd0);
    end
    step_fp(4'h8);
    expect_fp("fp_drop", 4'h0, 2'd0);
    step_fp(4'h8);
    expect_fp("fp_m3", 4'h8, 2'd3);
    step_fp(4'h0);
    expect_fp("fp_end", 4'h0, 2'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
